pll_reset_sequencer: RTL

- Sits directly downstream of the array's 48/96 MHz PLL and consumes its `locked` output.
- Drives the PLL's active-high reset and produces the debounced system reset that releases the mic-array capture logic.
- Runs on the free-running 48 MHz board reference clock, not a PLL output, so it keeps working while the PLL is unlocked.
- Retries PLL lock on timeout or lock loss and exposes saturating fault counters to the control interface.

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default cycle counts at 48 MHz, and the cycle-counter sizing helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int DEF_PLL_RST_CYCLES = 48;
  localparam int DEF_LOCK_TIMEOUT   = 48000;
  localparam int DEF_STABLE_CYCLES  = 4800;

  // The counter only ever needs to reach (largest period - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-zero so a
// synchronised level never appears asserted straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock wait and lock-stability qualification on the free
// running reference clock, then releases the capture-logic system reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             soft_req,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] PRST_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_lock_s;
  logic             w_timeout;
  logic             w_loss;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Priority in every state: soft_req, then lock change, then counter expiry.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_loss    = 1'b0;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == PRST_LAST) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (soft_req) begin
          w_next = ST_PLL_RST;
        end else if (w_lock_s) begin
          w_next = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next    = ST_PLL_RST;
          w_timeout = 1'b1;
        end
      end
      ST_STABLE: begin
        if (soft_req) begin
          w_next = ST_PLL_RST;
        end else if (!w_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (soft_req) begin
          w_next = ST_PLL_RST;
        end else if (!w_lock_s) begin
          w_next = ST_PLL_RST;
          w_loss = 1'b1;
        end
      end
      default: w_next = ST_PLL_RST;
    endcase
  end

  // Outputs decode the next state so they move on the transition edge itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_PLL_RST;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst_n   <= 1'b0;
      r_timeout_cnt <= '0;
      r_loss_cnt    <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_pll_rst   <= (w_next == ST_PLL_RST);
      r_sys_rst_n <= (w_next == ST_RUN);
      if (w_timeout) r_timeout_cnt <= sat_inc(r_timeout_cnt);
      if (w_loss)    r_loss_cnt    <= sat_inc(r_loss_cnt);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_reset_n   = r_sys_rst_n;
  assign ready         = r_sys_rst_n;
  assign state_o       = r_state;
  assign timeout_count = r_timeout_cnt;
  assign loss_count    = r_loss_cnt;

endmodule
